// File: rtl/player_hit_judge.sv
// Player collision judge: checks bullets against the player, tracks health and raises boom at zero.
// Optional feature macro: HIT_JUDGE_INVULN_EN enables the post-hit invulnerability window.
module player_hit_judge #(
  parameter int NUM_BULLETS   = 4,
  parameter int COORD_W       = 10,
  parameter int HEALTH_W      = 4,
  parameter int HIT_XL        = 10,
  parameter int HIT_XH        = 50,
  parameter int HIT_YL        = 50,
  parameter int HIT_YH        = 40,
  parameter int INVULN_FRAMES = 60
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic [COORD_W-1:0]             p_x,
  input  logic [COORD_W-1:0]             p_y,
  input  logic [NUM_BULLETS*COORD_W-1:0] eb_x,
  input  logic [NUM_BULLETS*COORD_W-1:0] eb_y,
  input  logic [NUM_BULLETS-1:0]         eb_en,
  input  logic                           player_en,
  input  logic                           load_health,
  input  logic [HEALTH_W-1:0]            health_init,
  output logic [NUM_BULLETS-1:0]         eb_clr,
  output logic                           hit,
  output logic [HEALTH_W-1:0]            health,
  output logic                           invuln,
  output logic                           boom
);

  // Two spare bits keep coordinate + offset sums from wrapping near screen edges.
  localparam int EXT_W = COORD_W + 2;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [NUM_BULLETS-1:0]  ov;
  logic [NUM_BULLETS-1:0]  eb_clr_nx;
  logic                    hit_nx;
  logic [HEALTH_W-1:0]     health_nx;
  logic [HEALTH_W-1:0]     health_dec;
  logic [EXT_W-1:0]        px_ext;
  logic [EXT_W-1:0]        py_ext;

  assign px_ext = EXT_W'(p_x);
  assign py_ext = EXT_W'(p_y);

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_ov
    logic [EXT_W-1:0] bx;
    logic [EXT_W-1:0] by;
    assign bx = EXT_W'(eb_x[i*COORD_W +: COORD_W]);
    assign by = EXT_W'(eb_y[i*COORD_W +: COORD_W]);
    assign ov[i] = eb_en[i] & player_en
                 & (bx <= px_ext + EXT_W'(HIT_XL))
                 & (px_ext < bx + EXT_W'(HIT_XH))
                 & (by <= py_ext + EXT_W'(HIT_YL))
                 & (py_ext < by + EXT_W'(HIT_YH));
  end

  // Saturating decrement so health can never wrap below zero.
  assign health_dec = (health != '0) ? health - HEALTH_W'(1) : '0;

`ifdef HIT_JUDGE_INVULN_EN
  localparam int CNT_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
`endif

  always_comb begin
    state_nx  = state;
    health_nx = health;
    eb_clr_nx = '0;
    hit_nx    = 1'b0;
`ifdef HIT_JUDGE_INVULN_EN
    cnt_nx    = cnt;
`endif
    if (load_health) begin
      health_nx = health_init;
      state_nx  = (health_init != '0) ? ALIVE : DEAD;
`ifdef HIT_JUDGE_INVULN_EN
      cnt_nx    = '0;
`endif
    end else begin
      case (state)
        ALIVE: begin
          if (|ov) begin
            eb_clr_nx = ov;
            hit_nx    = 1'b1;
            health_nx = health_dec;
            if (health_dec == '0) begin
              state_nx = DEAD;
            end else begin
`ifdef HIT_JUDGE_INVULN_EN
              state_nx = INVULN;
              cnt_nx   = CNT_W'(INVULN_FRAMES - 1);
`else
              state_nx = ALIVE;
`endif
            end
          end
        end
        INVULN: begin
`ifdef HIT_JUDGE_INVULN_EN
          if (frame_tick) begin
            if (cnt == '0) state_nx = ALIVE;
            else           cnt_nx   = cnt - CNT_W'(1);
          end
`else
          state_nx = ALIVE;
`endif
        end
        DEAD:    state_nx = DEAD;
        default: state_nx = DEAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= DEAD;
      health <= '0;
      eb_clr <= '0;
      hit    <= 1'b0;
    end else begin
      state  <= state_nx;
      health <= health_nx;
      eb_clr <= eb_clr_nx;
      hit    <= hit_nx;
    end
  end

`ifdef HIT_JUDGE_INVULN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nx;
  end

  assign invuln = (state == INVULN);
`else
  assign invuln = 1'b0;
`endif

  assign boom = (state == DEAD);

endmodule

// File: tb/tb_player_hit_judge.sv
// Randomised self-checking bench for player_hit_judge against a frame-counting behavioural model.
module tb_player_hit_judge;

  localparam int NB = 4;
  localparam int CW = 10;
  localparam int HW = 4;
  localparam int FRAMES = 60;
`ifdef HIT_JUDGE_INVULN_EN
  localparam bit INV_ON = 1'b1;
`else
  localparam bit INV_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           frame_tick = 1'b0;
  logic [CW-1:0]  p_x = '0;
  logic [CW-1:0]  p_y = '0;
  logic [NB*CW-1:0] eb_x = '0;
  logic [NB*CW-1:0] eb_y = '0;
  logic [NB-1:0]  eb_en = '0;
  logic           player_en = 1'b1;
  logic           load_health = 1'b0;
  logic [HW-1:0]  health_init = '0;
  logic [NB-1:0]  eb_clr;
  logic           hit;
  logic [HW-1:0]  health;
  logic           invuln;
  logic           boom;

  int total = 0;
  int bad = 0;

  player_hit_judge dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .p_x(p_x), .p_y(p_y),
    .eb_x(eb_x), .eb_y(eb_y), .eb_en(eb_en), .player_en(player_en),
    .load_health(load_health), .health_init(health_init),
    .eb_clr(eb_clr), .hit(hit), .health(health), .invuln(invuln), .boom(boom)
  );

  always #5 clk = ~clk;

  // Model: health==0 means dead; frames_left>0 means invulnerable for that many more ticks.
  int       m_health = 0;
  int       m_left = 0;
  bit [NB-1:0] m_clr = '0;
  bit       m_hit = 1'b0;

  function automatic bit [NB-1:0] model_ov();
    bit [NB-1:0] r = '0;
    for (int i = 0; i < NB; i++) begin
      int bx = int'(eb_x[i*CW +: CW]);
      int by = int'(eb_y[i*CW +: CW]);
      int px = int'(p_x);
      int py = int'(p_y);
      if (eb_en[i] && player_en && bx <= px + 10 && px < bx + 50 &&
          by <= py + 50 && py < by + 40)
        r[i] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_health = 0; m_left = 0; m_clr = '0; m_hit = 1'b0;
    end else begin
      bit [NB-1:0] o;
      o = model_ov();
      m_clr = '0;
      m_hit = 1'b0;
      if (load_health) begin
        m_health = int'(health_init);
        m_left = 0;
      end else if (m_health != 0) begin
        if (m_left > 0) begin
          if (frame_tick) m_left = m_left - 1;
        end else if (o != '0) begin
          m_clr = o;
          m_hit = 1'b1;
          m_health = m_health - 1;
          if (INV_ON && m_health != 0) m_left = FRAMES;
        end
      end
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every negedge the registered outputs must agree with the model.
  always @(negedge clk) begin
    chk("eb_clr", int'(eb_clr), int'(m_clr));
    chk("hit", int'(hit), int'(m_hit));
    chk("health", int'(health), m_health);
    chk("invuln", int'(invuln), int'(m_left > 0));
    chk("boom", int'(boom), int'(m_health == 0));
  end

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic set_bullet(input int i, input int x, input int y, input bit en);
    eb_x[i*CW +: CW] = CW'(x);
    eb_y[i*CW +: CW] = CW'(y);
    eb_en[i] = en;
  endtask

  task automatic load(input int v);
    load_health = 1'b1;
    health_init = HW'(v);
    cycle();
    load_health = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset_health", int'(health), 0);
    chk("reset_boom", int'(boom), 1);
    chk("reset_invuln", int'(invuln), 0);

    load(3);
    chk("load_health", int'(health), 3);
    chk("load_boom", int'(boom), 0);
    chk("load_clr", int'(eb_clr), 0);

    p_x = 10'd100; p_y = 10'd200;
    set_bullet(0, 95, 180, 1'b1);
    cycle();
    eb_en = '0;
    chk("single_clr", int'(eb_clr), 1);
    chk("single_hit", int'(hit), 1);
    chk("single_health", int'(health), 2);
    chk("single_invuln", int'(invuln), int'(INV_ON));
    cycle();
    chk("single_hit_pulse", int'(hit), 0);

    load(3);
    set_bullet(0, 200, 200, 1'b1);
    cycle();
    chk("far_no_hit", int'(hit), 0);

    set_bullet(1, 95, 180, 1'b1);
    set_bullet(3, 95, 180, 1'b1);
    cycle();
    eb_en = '0;
    chk("multi_clr", int'(eb_clr), 4'b1010);
    chk("multi_health", int'(health), 2);

`ifdef HIT_JUDGE_INVULN_EN
    set_bullet(0, 95, 180, 1'b1);
    cycle();
    chk("inv_no_clr", int'(eb_clr), 0);
    chk("inv_health", int'(health), 2);
    for (int i = 0; i < FRAMES; i++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      if (i < FRAMES - 1) cycle();
    end
    chk("inv_expired", int'(invuln), 0);
    chk("inv_health_kept", int'(health), 2);
    cycle();
    eb_en = '0;
    chk("post_inv_hit", int'(hit), 1);
    chk("post_inv_health", int'(health), 1);
`endif

    load(1);
    set_bullet(0, 95, 180, 1'b1);
    cycle();
    chk("fatal_health", int'(health), 0);
    chk("fatal_boom", int'(boom), 1);
    cycle();
    eb_en = '0;
    chk("dead_no_hit", int'(hit), 0);
    chk("dead_no_clr", int'(eb_clr), 0);
    load(2);
    chk("revive_boom", int'(boom), 0);
    chk("revive_health", int'(health), 2);

    p_x = 10'd0;
    set_bullet(0, 1020, 180, 1'b1);
    cycle();
    chk("edge_low_no_wrap", int'(hit), 0);
    p_x = 10'd1020;
    set_bullet(0, 0, 180, 1'b1);
    cycle();
    chk("edge_high_no_wrap", int'(hit), 0);

    p_x = 10'd100;
    set_bullet(0, 95, 180, 1'b1);
    load_health = 1'b1;
    health_init = 4'd5;
    cycle();
    load_health = 1'b0;
    eb_en = '0;
    chk("load_prio_health", int'(health), 5);
    chk("load_prio_hit", int'(hit), 0);

    set_bullet(0, 95, 180, 1'b1);
    cycle();
    eb_en = '0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_health", int'(health), 0);
    chk("async_rst_boom", int'(boom), 1);
    chk("async_rst_invuln", int'(invuln), 0);
    cycle();
    rst = 1'b0;
    load(9);

    for (int n = 0; n < 3000; n++) begin
      p_x = CW'($urandom_range(0, 1023));
      p_y = CW'($urandom_range(0, 1023));
      for (int i = 0; i < NB; i++)
        set_bullet(i, (int'(p_x) + int'($urandom_range(0, 130)) - 65) & 1023,
                   (int'(p_y) + int'($urandom_range(0, 130)) - 65) & 1023,
                   bit'($urandom_range(0, 3) == 0));
      player_en = ($urandom_range(0, 9) != 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      load_health = ($urandom_range(0, 39) == 0);
      health_init = HW'($urandom_range(0, 15));
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;
    load_health = 1'b0;
    eb_en = '0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
